// File: rtl/tlb_multiport.sv
// -----------------------------------------------------------------------------
// tlb_multiport
//
// MIPS-style joint TLB with a configurable number of entries and independent
// search ports. It sits between the fetch/memory translation stages and the
// CP0 TLB-instruction logic (TLBP/TLBR/TLBWI/TLBWR).
//
// Ports:
//   clk, reset            clock (rising edge) and asynchronous active-high reset
//   s_req/s_vpn2/s_odd_page/s_asid
//                         per-port lookup request; port p uses slice p
//   s_resp/s_found/s_multi/s_index/s_pfn/s_c/s_d/s_v
//                         per-port registered lookup result, one cycle after s_req
//   we, w_random, w_index, w_* fields
//                         entry write (target is Random or w_index)
//   wired_we, wired_in    Wired register load (also reloads Random)
//   flush                 invalidate every entry
//   r_req, r_index        entry read request
//   r_resp, r_* fields    registered read data, one cycle after r_req
//   random                current Random register
// -----------------------------------------------------------------------------
module tlb_multiport #(
    parameter int TLB_NUM      = 16,
    parameter int SEARCH_PORTS = 2,
    parameter int VPN2_W       = 19,
    parameter int PFN_W        = 20,
    parameter int ASID_W       = 8,
    localparam int IDX_W       = $clog2(TLB_NUM)
) (
    input  logic                           clk,
    input  logic                           reset,

    input  logic [SEARCH_PORTS-1:0]        s_req,
    input  logic [SEARCH_PORTS*VPN2_W-1:0] s_vpn2,
    input  logic [SEARCH_PORTS-1:0]        s_odd_page,
    input  logic [SEARCH_PORTS*ASID_W-1:0] s_asid,
    output logic [SEARCH_PORTS-1:0]        s_resp,
    output logic [SEARCH_PORTS-1:0]        s_found,
    output logic [SEARCH_PORTS-1:0]        s_multi,
    output logic [SEARCH_PORTS*IDX_W-1:0]  s_index,
    output logic [SEARCH_PORTS*PFN_W-1:0]  s_pfn,
    output logic [SEARCH_PORTS*3-1:0]      s_c,
    output logic [SEARCH_PORTS-1:0]        s_d,
    output logic [SEARCH_PORTS-1:0]        s_v,

    input  logic                           we,
    input  logic                           w_random,
    input  logic [IDX_W-1:0]               w_index,
    input  logic [VPN2_W-1:0]              w_vpn2,
    input  logic [ASID_W-1:0]              w_asid,
    input  logic                           w_g,
    input  logic [PFN_W-1:0]               w_pfn0,
    input  logic [2:0]                     w_c0,
    input  logic                           w_d0,
    input  logic                           w_v0,
    input  logic [PFN_W-1:0]               w_pfn1,
    input  logic [2:0]                     w_c1,
    input  logic                           w_d1,
    input  logic                           w_v1,

    input  logic                           wired_we,
    input  logic [IDX_W-1:0]               wired_in,
    input  logic                           flush,

    input  logic                           r_req,
    input  logic [IDX_W-1:0]               r_index,
    output logic                           r_resp,
    output logic [VPN2_W-1:0]              r_vpn2,
    output logic [ASID_W-1:0]              r_asid,
    output logic                           r_g,
    output logic [PFN_W-1:0]               r_pfn0,
    output logic [2:0]                     r_c0,
    output logic                           r_d0,
    output logic                           r_v0,
    output logic [PFN_W-1:0]               r_pfn1,
    output logic [2:0]                     r_c1,
    output logic                           r_d1,
    output logic                           r_v1,

    output logic [IDX_W-1:0]               random
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TLB_NUM - 1);

    typedef struct packed {
        logic [VPN2_W-1:0] vpn2;
        logic [ASID_W-1:0] asid;
        logic              g;
        logic [PFN_W-1:0]  pfn0;
        logic [2:0]        c0;
        logic              d0;
        logic              v0;
        logic [PFN_W-1:0]  pfn1;
        logic [2:0]        c1;
        logic              d1;
        logic              v1;
    } entry_t;

    // Entry fields live in plain registers (every port compares all entries
    // in parallel); only the exist bits need a reset.
    entry_t             tlb_mem [TLB_NUM];
    logic [TLB_NUM-1:0] e_reg;

    logic [IDX_W-1:0]   random_reg;
    logic [IDX_W-1:0]   random_next;
    logic [IDX_W-1:0]   wired_reg;

    entry_t             w_entry;
    logic [IDX_W-1:0]   w_target;

    logic               r_resp_reg;
    entry_t             r_entry_reg;

    assign w_entry = '{vpn2: w_vpn2, asid: w_asid, g: w_g,
                       pfn0: w_pfn0, c0: w_c0, d0: w_d0, v0: w_v0,
                       pfn1: w_pfn1, c1: w_c1, d1: w_d1, v1: w_v1};

    // A random write always uses the Random value from before this edge.
    assign w_target = w_random ? random_reg : w_index;

    // -------------------------------------------------------------------------
    // Table storage
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (we) begin
            tlb_mem[w_target] <= w_entry;
        end
    end

    // Flush clears everything first; a simultaneous write then re-validates
    // its own target because the later assignment wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_reg <= '0;
        end else begin
            if (flush) begin
                e_reg <= '0;
            end
            if (we) begin
                e_reg[w_target] <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Random / Wired
    // -------------------------------------------------------------------------
    // Random cycles over wired+1 .. TLB_NUM-1: it wraps once the decremented
    // value would reach Wired. When Wired >= TLB_NUM-1 the wrap condition is
    // always true, so Random is pinned at TLB_NUM-1.
    always_comb begin
        random_next = random_reg;
        if (wired_we) begin
            random_next = LAST_IDX;
        end else if (we && w_random) begin
            if ({1'b0, random_reg} <= ({1'b0, wired_reg} + (IDX_W+1)'(1))) begin
                random_next = LAST_IDX;
            end else begin
                random_next = random_reg - IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            random_reg <= LAST_IDX;
            wired_reg  <= '0;
        end else begin
            random_reg <= random_next;
            if (wired_we) begin
                wired_reg <= wired_in;
            end
        end
    end

    assign random = random_reg;

    // -------------------------------------------------------------------------
    // Search ports
    // -------------------------------------------------------------------------
    genvar gi, gj;
    generate
        for (gi = 0; gi < SEARCH_PORTS; gi++) begin : g_port
            logic [VPN2_W-1:0]  q_vpn2;
            logic [ASID_W-1:0]  q_asid;
            logic               q_odd;
            logic [TLB_NUM-1:0] match;
            logic [IDX_W-1:0]   hit_idx;
            logic               hit;
            logic               hit_multi;
            logic [PFN_W-1:0]   sel_pfn;
            logic [2:0]         sel_c;
            logic               sel_d;
            logic               sel_v;

            logic               resp_reg;
            logic               found_reg;
            logic               multi_reg;
            logic [IDX_W-1:0]   index_reg;
            logic [PFN_W-1:0]   pfn_reg;
            logic [2:0]         c_reg;
            logic               d_reg;
            logic               v_reg;

            assign q_vpn2 = s_vpn2[gi*VPN2_W +: VPN2_W];
            assign q_asid = s_asid[gi*ASID_W +: ASID_W];
            assign q_odd  = s_odd_page[gi];

            for (gj = 0; gj < TLB_NUM; gj++) begin : g_cmp
                assign match[gj] = e_reg[gj]
                                && (tlb_mem[gj].vpn2 == q_vpn2)
                                && (tlb_mem[gj].g || (tlb_mem[gj].asid == q_asid));
            end

            // Scan from the top so the lowest matching index is the survivor.
            always_comb begin
                hit_idx = '0;
                for (int i = TLB_NUM - 1; i >= 0; i--) begin
                    if (match[i]) begin
                        hit_idx = IDX_W'(i);
                    end
                end
            end

            assign hit = |match;
            // Clearing the lowest set bit leaves something iff >= 2 bits set.
            assign hit_multi = |(match & (match - TLB_NUM'(1)));

            always_comb begin
                sel_pfn = '0;
                sel_c   = '0;
                sel_d   = 1'b0;
                sel_v   = 1'b0;
                if (hit) begin
                    if (q_odd) begin
                        sel_pfn = tlb_mem[hit_idx].pfn1;
                        sel_c   = tlb_mem[hit_idx].c1;
                        sel_d   = tlb_mem[hit_idx].d1;
                        sel_v   = tlb_mem[hit_idx].v1;
                    end else begin
                        sel_pfn = tlb_mem[hit_idx].pfn0;
                        sel_c   = tlb_mem[hit_idx].c0;
                        sel_d   = tlb_mem[hit_idx].d0;
                        sel_v   = tlb_mem[hit_idx].v0;
                    end
                end
            end

            // Result registers only load on a request so idle cycles hold
            // the previous answer.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    resp_reg  <= 1'b0;
                    found_reg <= 1'b0;
                    multi_reg <= 1'b0;
                    index_reg <= '0;
                    pfn_reg   <= '0;
                    c_reg     <= '0;
                    d_reg     <= 1'b0;
                    v_reg     <= 1'b0;
                end else begin
                    resp_reg <= s_req[gi];
                    if (s_req[gi]) begin
                        found_reg <= hit;
                        multi_reg <= hit_multi;
                        index_reg <= hit_idx;
                        pfn_reg   <= sel_pfn;
                        c_reg     <= sel_c;
                        d_reg     <= sel_d;
                        v_reg     <= sel_v;
                    end
                end
            end

            assign s_resp[gi]                   = resp_reg;
            assign s_found[gi]                  = found_reg;
            assign s_multi[gi]                  = multi_reg;
            assign s_index[gi*IDX_W +: IDX_W]   = index_reg;
            assign s_pfn[gi*PFN_W +: PFN_W]     = pfn_reg;
            assign s_c[gi*3 +: 3]               = c_reg;
            assign s_d[gi]                      = d_reg;
            assign s_v[gi]                      = v_reg;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Read port (TLBR): raw stored fields, exist bit not consulted
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_resp_reg  <= 1'b0;
            r_entry_reg <= '0;
        end else begin
            r_resp_reg <= r_req;
            if (r_req) begin
                r_entry_reg <= tlb_mem[r_index];
            end
        end
    end

    assign r_resp = r_resp_reg;
    assign r_vpn2 = r_entry_reg.vpn2;
    assign r_asid = r_entry_reg.asid;
    assign r_g    = r_entry_reg.g;
    assign r_pfn0 = r_entry_reg.pfn0;
    assign r_c0   = r_entry_reg.c0;
    assign r_d0   = r_entry_reg.d0;
    assign r_v0   = r_entry_reg.v0;
    assign r_pfn1 = r_entry_reg.pfn1;
    assign r_c1   = r_entry_reg.c1;
    assign r_d1   = r_entry_reg.d1;
    assign r_v1   = r_entry_reg.v1;

endmodule

// File: tb/tb_tlb_multiport.sv
// -----------------------------------------------------------------------------
// tb_tlb_multiport
//
// Self-checking bench for tlb_multiport (default parameters). Stimulus is
// driven on the falling edge; expected search/read results are computed from
// a behavioural table model at drive time, queued, and compared by a monitor
// one time unit after the following rising edge.
// -----------------------------------------------------------------------------
module tb_tlb_multiport;

    localparam int NP = 2;
    localparam int NE = 16;

    typedef struct packed {
        logic        found;
        logic        multi;
        logic [3:0]  index;
        logic [19:0] pfn;
        logic [2:0]  c;
        logic        d;
        logic        v;
    } exp_t;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } rd_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  s_req, s_odd_page;
    logic [37:0] s_vpn2;
    logic [15:0] s_asid;
    logic [1:0]  s_resp, s_found, s_multi, s_d, s_v;
    logic [7:0]  s_index;
    logic [39:0] s_pfn;
    logic [5:0]  s_c;
    logic        we, w_random, w_g, w_d0, w_v0, w_d1, w_v1;
    logic [3:0]  w_index;
    logic [18:0] w_vpn2;
    logic [7:0]  w_asid;
    logic [19:0] w_pfn0, w_pfn1;
    logic [2:0]  w_c0, w_c1;
    logic        wired_we, flush, r_req;
    logic [3:0]  wired_in, r_index;
    logic        r_resp, r_g, r_d0, r_v0, r_d1, r_v1;
    logic [18:0] r_vpn2;
    logic [7:0]  r_asid;
    logic [19:0] r_pfn0, r_pfn1;
    logic [2:0]  r_c0, r_c1;
    logic [3:0]  random;

    tlb_multiport dut (
        .clk(clk), .reset(reset),
        .s_req(s_req), .s_vpn2(s_vpn2), .s_odd_page(s_odd_page), .s_asid(s_asid),
        .s_resp(s_resp), .s_found(s_found), .s_multi(s_multi), .s_index(s_index),
        .s_pfn(s_pfn), .s_c(s_c), .s_d(s_d), .s_v(s_v),
        .we(we), .w_random(w_random), .w_index(w_index),
        .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
        .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
        .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
        .wired_we(wired_we), .wired_in(wired_in), .flush(flush),
        .r_req(r_req), .r_index(r_index), .r_resp(r_resp),
        .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
        .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
        .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1),
        .random(random)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(string tag, logic [127:0] got, logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural reference table ----------------
    logic [18:0] m_vpn2 [NE];
    logic [7:0]  m_asid [NE];
    logic        m_g    [NE];
    logic [19:0] m_pfn0 [NE], m_pfn1 [NE];
    logic [2:0]  m_c0   [NE], m_c1   [NE];
    logic        m_d0   [NE], m_v0   [NE], m_d1 [NE], m_v1 [NE];
    logic        m_e    [NE];
    logic [3:0]  m_random;
    logic [3:0]  m_wired;

    exp_t sq [NP][$];
    rd_t  rq [$];
    exp_t last_exp [NP];
    bit   mon_en = 1'b0;

    function automatic exp_t model_search(logic [18:0] vpn2, logic [7:0] asid, logic odd);
        exp_t r;
        int   cnt;
        r   = '0;
        cnt = 0;
        for (int i = 0; i < NE; i++) begin
            if (m_e[i] && m_vpn2[i] == vpn2 && (m_g[i] || m_asid[i] == asid)) begin
                if (cnt == 0) begin
                    r.index = i[3:0];
                    r.pfn   = odd ? m_pfn1[i] : m_pfn0[i];
                    r.c     = odd ? m_c1[i]   : m_c0[i];
                    r.d     = odd ? m_d1[i]   : m_d0[i];
                    r.v     = odd ? m_v1[i]   : m_v0[i];
                end
                cnt++;
            end
        end
        r.found = (cnt > 0);
        r.multi = (cnt > 1);
        return r;
    endfunction

    function automatic rd_t model_read(logic [3:0] idx);
        return '{vpn2: m_vpn2[idx], asid: m_asid[idx], g: m_g[idx],
                 pfn0: m_pfn0[idx], c0: m_c0[idx], d0: m_d0[idx], v0: m_v0[idx],
                 pfn1: m_pfn1[idx], c1: m_c1[idx], d1: m_d1[idx], v1: m_v1[idx]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NE; i++) m_e[i] = 1'b0;
        m_random = 4'd15;
        m_wired  = 4'd0;
        for (int p = 0; p < NP; p++) last_exp[p] = '0;
    endtask

    task automatic clear_inputs();
        s_req = '0; s_odd_page = '0; s_vpn2 = '0; s_asid = '0;
        we = 0; w_random = 0; w_index = '0; w_vpn2 = '0; w_asid = '0; w_g = 0;
        w_pfn0 = '0; w_c0 = '0; w_d0 = 0; w_v0 = 0;
        w_pfn1 = '0; w_c1 = '0; w_d1 = 0; w_v1 = 0;
        wired_we = 0; wired_in = '0; flush = 0; r_req = 0; r_index = '0;
    endtask

    task automatic set_search(int p, logic [18:0] vpn2, logic [7:0] asid, logic odd);
        s_req[p] = 1'b1;
        s_vpn2[p*19 +: 19] = vpn2;
        s_asid[p*8 +: 8]   = asid;
        s_odd_page[p]      = odd;
    endtask

    task automatic set_write(logic rnd, logic [3:0] idx, logic [18:0] vpn2,
                             logic [7:0] asid, logic g,
                             logic [19:0] pfn0, logic [2:0] c0, logic d0, logic v0,
                             logic [19:0] pfn1, logic [2:0] c1, logic d1, logic v1);
        we = 1; w_random = rnd; w_index = idx; w_vpn2 = vpn2; w_asid = asid; w_g = g;
        w_pfn0 = pfn0; w_c0 = c0; w_d0 = d0; w_v0 = v0;
        w_pfn1 = pfn1; w_c1 = c1; w_d1 = d1; w_v1 = v1;
    endtask

    // Called on a falling edge with inputs set: queue expectations from the
    // pre-edge table, apply the edge to the model, advance to the next fall.
    task automatic cycle();
        logic [3:0] tgt;
        int         nxt;
        for (int p = 0; p < NP; p++) begin
            if (s_req[p]) sq[p].push_back(model_search(s_vpn2[p*19 +: 19], s_asid[p*8 +: 8], s_odd_page[p]));
        end
        if (r_req) rq.push_back(model_read(r_index));
        tgt = w_random ? m_random : w_index;
        if (flush) begin
            for (int i = 0; i < NE; i++) m_e[i] = 1'b0;
        end
        if (we) begin
            m_vpn2[tgt] = w_vpn2; m_asid[tgt] = w_asid; m_g[tgt] = w_g;
            m_pfn0[tgt] = w_pfn0; m_c0[tgt] = w_c0; m_d0[tgt] = w_d0; m_v0[tgt] = w_v0;
            m_pfn1[tgt] = w_pfn1; m_c1[tgt] = w_c1; m_d1[tgt] = w_d1; m_v1[tgt] = w_v1;
            m_e[tgt] = 1'b1;
        end
        if (wired_we) begin
            m_wired  = wired_in;
            m_random = 4'd15;
        end else if (we && w_random) begin
            nxt = int'(m_random) - 1;
            if (m_wired >= 4'd15 || nxt <= int'(m_wired)) m_random = 4'd15;
            else m_random = nxt[3:0];
        end
        @(negedge clk);
        clear_inputs();
    endtask

    // ---------------- monitor ----------------
    exp_t mon_e;
    exp_t mon_got;
    rd_t  mon_r;
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            for (int p = 0; p < NP; p++) begin
                mon_got = {s_found[p], s_multi[p], s_index[p*4 +: 4], s_pfn[p*20 +: 20],
                           s_c[p*3 +: 3], s_d[p], s_v[p]};
                if (s_resp[p]) begin
                    if (sq[p].size() == 0) begin
                        check_val($sformatf("s_resp_unexpected_p%0d", p), 1, 0);
                    end else begin
                        mon_e = sq[p].pop_front();
                        check_val($sformatf("search_p%0d", p), mon_got, mon_e);
                        last_exp[p] = mon_e;
                        $display("[TB] t=%0t search p%0d found=%0b multi=%0b idx=%0d pfn=0x%05h",
                                 $time, p, mon_got.found, mon_got.multi, mon_got.index, mon_got.pfn);
                    end
                end else if (sq[p].size() != 0) begin
                    void'(sq[p].pop_front());
                    check_val($sformatf("s_resp_missing_p%0d", p), 0, 1);
                end else begin
                    check_val($sformatf("search_hold_p%0d", p), mon_got, last_exp[p]);
                end
            end
            if (r_resp) begin
                if (rq.size() == 0) begin
                    check_val("r_resp_unexpected", 1, 0);
                end else begin
                    mon_r = rq.pop_front();
                    check_val("read", {r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0,
                                       r_pfn1, r_c1, r_d1, r_v1}, mon_r);
                    $display("[TB] t=%0t read vpn2=0x%05h asid=0x%02h", $time, r_vpn2, r_asid);
                end
            end else if (rq.size() != 0) begin
                void'(rq.pop_front());
                check_val("r_resp_missing", 0, 1);
            end
            check_val("random", random, m_random);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish (got timeout, required finish)");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        clear_inputs();
        model_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_s_resp",  s_resp,  0);
        check_val("rst_s_found", s_found, 0);
        check_val("rst_s_index", s_index, 0);
        check_val("rst_r_resp",  r_resp,  0);
        check_val("rst_random",  random,  15);
        @(negedge clk);
        reset  = 1'b0;
        mon_en = 1'b1;

        // Empty table: every port misses.
        set_search(0, 19'h00000, 8'h00, 1'b0);
        set_search(1, 19'h00000, 8'h00, 1'b0);
        cycle();
        check_val("empty_resp",  s_resp,  2'b11);
        check_val("empty_found", s_found, 2'b00);
        check_val("empty_multi", s_multi, 2'b00);
        check_val("empty_index", s_index, 8'h00);

        // Indexed write at 5, ASID-qualified search on two ports.
        set_write(0, 4'd5, 19'h12345, 8'h3A, 0, 20'h00111, 3'd2, 0, 1, 20'h00222, 3'd3, 1, 0);
        cycle();
        set_search(0, 19'h12345, 8'h3A, 1'b1);
        set_search(1, 19'h12345, 8'h3B, 1'b0);
        cycle();
        check_val("w5_found0", s_found[0], 1);
        check_val("w5_index0", s_index[3:0], 5);
        check_val("w5_pfn0",   s_pfn[19:0], 20'h00222);
        check_val("w5_d0",     s_d[0], 1);
        check_val("w5_found1", s_found[1], 0);
        cycle();  // idle: outputs must hold

        // Wired = 3, then 14 random writes.
        wired_we = 1; wired_in = 4'd3;
        cycle();
        for (int k = 0; k < 14; k++) begin
            check_val($sformatf("rnd_target_%0d", k), random, (k < 12) ? 15 - k : 27 - k);
            set_write(1, 4'd0, 19'h40000 + 19'(k), 8'(k), 0, 20'(k), 3'd1, 1, 1, 20'(k + 100), 3'd2, 0, 1);
            cycle();
        end
        check_val("rnd_after14", random, 13);
        r_req = 1; r_index = 4'd4;
        cycle();
        check_val("rnd_entry4", r_vpn2, 19'h4000B);
        r_req = 1; r_index = 4'd15;
        cycle();
        check_val("rnd_entry15", r_vpn2, 19'h4000C);

        // Global entries at 2 and 9: multi-hit, lowest index wins; then flush.
        set_write(0, 4'd2, 19'h00abc, 8'h01, 1, 20'h0AAA0, 3'd4, 0, 1, 20'h0BBB0, 3'd5, 1, 1);
        cycle();
        set_write(0, 4'd9, 19'h00abc, 8'h02, 1, 20'h0CCC0, 3'd6, 1, 0, 20'h0DDD0, 3'd7, 0, 0);
        cycle();
        set_search(0, 19'h00abc, 8'h55, 1'b0);
        set_search(1, 19'h00abc, 8'h11, 1'b1);
        cycle();
        check_val("g_found", s_found, 2'b11);
        check_val("g_index", s_index, 8'h22);
        check_val("g_multi", s_multi, 2'b11);
        check_val("g_pfn1",  s_pfn[39:20], 20'h0BBB0);
        flush = 1;
        cycle();
        set_search(0, 19'h00abc, 8'h55, 1'b0);
        set_search(1, 19'h00abc, 8'h01, 1'b1);
        cycle();
        check_val("flush_found", s_found, 2'b00);
        check_val("flush_index", s_index, 8'h00);

        // Read-before-write on index 7.
        set_write(0, 4'd7, 19'h07007, 8'h07, 0, 20'h07000, 3'd1, 0, 1, 20'h07001, 3'd1, 0, 1);
        cycle();
        set_write(0, 4'd7, 19'h07770, 8'h07, 0, 20'h07770, 3'd2, 1, 1, 20'h07771, 3'd2, 1, 1);
        set_search(0, 19'h07007, 8'h07, 1'b0);
        set_search(1, 19'h07770, 8'h07, 1'b0);
        r_req = 1; r_index = 4'd7;
        cycle();
        check_val("rbw_old_found", s_found, 2'b01);
        check_val("rbw_old_read",  r_vpn2, 19'h07007);
        set_search(0, 19'h07770, 8'h07, 1'b1);
        set_search(1, 19'h07007, 8'h07, 1'b0);
        r_req = 1; r_index = 4'd7;
        cycle();
        check_val("rbw_new_found", s_found, 2'b01);
        check_val("rbw_new_pfn",   s_pfn[19:0], 20'h07771);
        check_val("rbw_new_read",  r_vpn2, 19'h07770);

        // Flush together with a write: only the written entry survives.
        set_write(0, 4'd3, 19'h03333, 8'h03, 0, 20'h03330, 3'd0, 0, 1, 20'h03331, 3'd0, 0, 1);
        cycle();
        flush = 1;
        set_write(0, 4'd10, 19'h0dddd, 8'h0A, 0, 20'h0DD00, 3'd3, 1, 1, 20'h0DD01, 3'd3, 1, 1);
        cycle();
        set_search(0, 19'h03333, 8'h03, 1'b0);
        set_search(1, 19'h0dddd, 8'h0A, 1'b0);
        cycle();
        check_val("flushwe_found", s_found, 2'b10);
        check_val("flushwe_index", s_index[7:4], 10);

        // Wired at the top: Random pinned at 15, and wired_we beats a decrement.
        wired_we = 1; wired_in = 4'd15;
        cycle();
        set_write(1, 4'd0, 19'h0F0F0, 8'h0F, 0, 20'h0F0F0, 3'd0, 0, 1, 20'h0F0F1, 3'd0, 0, 1);
        cycle();
        check_val("wired15_random", random, 15);
        wired_we = 1; wired_in = 4'd0;
        cycle();
        set_write(1, 4'd0, 19'h0E0E0, 8'h0E, 0, 20'h0E0E0, 3'd0, 0, 1, 20'h0E0E1, 3'd0, 0, 1);
        cycle();
        check_val("wired0_random", random, 14);
        wired_we = 1; wired_in = 4'd2;
        set_write(1, 4'd0, 19'h0E0E1, 8'h0E, 0, 20'h0E0E2, 3'd0, 0, 1, 20'h0E0E3, 3'd0, 0, 1);
        cycle();
        check_val("wiredwe_prio", random, 15);
        set_search(0, 19'h0E0E1, 8'h0E, 1'b0);
        cycle();
        check_val("wiredwe_target", s_index[3:0], 14);

        // Reset while a lookup is in flight: response dropped, table empty.
        set_search(0, 19'h0dddd, 8'h0A, 1'b0);
        set_search(1, 19'h0dddd, 8'h0A, 1'b0);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_val("rst_mid_async_resp", s_resp, 2'b00);
        @(posedge clk);
        #1;
        check_val("rst_mid_resp", s_resp, 2'b00);
        @(negedge clk);
        reset = 1'b0;
        clear_inputs();
        set_search(0, 19'h0dddd, 8'h0A, 1'b0);
        set_search(1, 19'h07770, 8'h07, 1'b0);
        cycle();
        check_val("rst_mid_found", s_found, 2'b00);
        check_val("rst_mid_random", random, 15);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
